// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller: FSM encodings, LED width
// and default timing constants for a 600 Hz LED clock.
package led_mode_ctrl_pkg;

  localparam int LED_W             = 8;
  localparam int DEF_NUM_MODES     = 4;
  localparam int DEF_MODE_W        = 2;
  localparam int DEF_DEB_CYCLES    = 12;
  localparam int DEF_LONG_CYCLES   = 600;
  localparam int DEF_BLANK_CYCLES  = 60;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BLANK   = 2'd1,
    ST_RESTART = 2'd2
  } led_state_e;

endpackage

// File: rtl/led_mode_ctrl_key_debounce.sv
// Key front end: two-flop synchronizer, level debounce and hold timer that
// turn a bouncy active-low button into short/long press events.
module key_debounce
  import led_mode_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic short_ev,
  output logic long_ev
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              sync1_q, sync2_q;
  logic              deb_q, deb_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              key_pressed_s;
  logic              flip_s;

  // Next-state for debounce and hold counters plus the press events.
  always_comb begin
    key_pressed_s = ~sync2_q;
    flip_s        = 1'b0;
    deb_d         = deb_q;
    deb_cnt_d     = deb_cnt_q;
    if (key_pressed_s != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        flip_s    = 1'b1;
        deb_d     = ~deb_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end

    if (deb_q) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d = '0;
    end

    // A release flip on the threshold cycle counts as a short press, so the
    // two events can never coincide.
    long_ev  = deb_q && !flip_s && (hold_q == HOLD_LAST);
    short_ev = deb_q && flip_s && (hold_q < HOLD_MAX);
  end

  // Synchronizer and debounce state; the key idles released (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      hold_q    <= '0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      hold_q    <= hold_d;
    end
  end

  assign pressed = deb_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED effect mode controller: steps through effect modes on key presses,
// blanks the LEDs between modes and restarts the drivers on each change.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int NUM_MODES    = DEF_NUM_MODES,
  parameter int MODE_W       = DEF_MODE_W,
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES  = DEF_LONG_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_n,
  input  logic [LED_W*NUM_MODES-1:0]   mode_led,
  output logic [MODE_W-1:0]            mode_sel,
  output logic                         drv_rst_n,
  output logic [LED_W-1:0]             led_out
);

  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  led_state_e         state_q;
  logic [MODE_W-1:0]  mode_sel_q, mode_next_q;
  logic [BLANK_W-1:0] blank_cnt_q;
  logic [LED_W-1:0]   led_q;
  logic               drv_rst_n_q;
  logic               pressed_s, short_ev_s, long_ev_s;

  function automatic logic [LED_W-1:0] pick_pattern(
    input logic [LED_W*NUM_MODES-1:0] leds,
    input logic [MODE_W-1:0]          sel
  );
    logic [LED_W-1:0] pat;
    pat = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (sel == MODE_W'(k)) begin
        pat = leds[k*LED_W +: LED_W];
      end else begin
        pat = pat;
      end
    end
    return pat;
  endfunction

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur);
    if (cur >= MODE_W'(NUM_MODES - 1)) begin
      return '0;
    end else begin
      return cur + MODE_W'(1);
    end
  endfunction

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES)
  ) u_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n   (key_n),
    .pressed (pressed_s),
    .short_ev(short_ev_s),
    .long_ev (long_ev_s)
  );

  // Mode FSM with registered LED pattern and driver restart outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESTART;
      mode_sel_q  <= '0;
      mode_next_q <= '0;
      blank_cnt_q <= '0;
      led_q       <= '0;
      drv_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          drv_rst_n_q <= 1'b1;
          if (long_ev_s && pressed_s) begin
            mode_next_q <= '0;
            blank_cnt_q <= '0;
            led_q       <= '0;
            state_q     <= ST_BLANK;
          end else if (short_ev_s) begin
            mode_next_q <= next_mode(mode_sel_q);
            blank_cnt_q <= '0;
            led_q       <= '0;
            state_q     <= ST_BLANK;
          end else begin
            led_q       <= pick_pattern(mode_led, mode_sel_q);
          end
        end
        // Key events arriving here are dropped rather than queued.
        ST_BLANK: begin
          led_q <= '0;
          if (blank_cnt_q == BLANK_LAST) begin
            blank_cnt_q <= '0;
            mode_sel_q  <= mode_next_q;
            drv_rst_n_q <= 1'b0;
            state_q     <= ST_RESTART;
          end else begin
            blank_cnt_q <= blank_cnt_q + BLANK_W'(1);
            drv_rst_n_q <= 1'b1;
          end
        end
        ST_RESTART: begin
          led_q       <= '0;
          drv_rst_n_q <= 1'b1;
          state_q     <= ST_RUN;
        end
        default: begin
          led_q       <= '0;
          mode_sel_q  <= '0;
          blank_cnt_q <= '0;
          drv_rst_n_q <= 1'b0;
          state_q     <= ST_RESTART;
        end
      endcase
    end
  end

  assign mode_sel  = mode_sel_q;
  assign drv_rst_n = drv_rst_n_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with short timing (DEB=4, LONG=20, BLANK=6);
// a second instance with a longer gap exercises presses that land in BLANK.
module tb_led_mode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_n;
  logic        key_b_n;
  logic [31:0] mode_led;
  logic [1:0]  mode_sel, mode_sel_b;
  logic        drv_rst_n, drv_rst_n_b;
  logic [7:0]  led_out, led_out_b;

  int n_checks  = 0;
  int n_bad     = 0;
  int pulse_cnt = 0;
  int p0;
  int bad_cyc;

  led_mode_ctrl #(
    .NUM_MODES(4), .MODE_W(2), .DEB_CYCLES(4), .LONG_CYCLES(20), .BLANK_CYCLES(6)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .mode_led(mode_led),
    .mode_sel(mode_sel), .drv_rst_n(drv_rst_n), .led_out(led_out)
  );

  led_mode_ctrl #(
    .NUM_MODES(4), .MODE_W(2), .DEB_CYCLES(4), .LONG_CYCLES(20), .BLANK_CYCLES(12)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .key_n(key_b_n), .mode_led(mode_led),
    .mode_sel(mode_sel_b), .drv_rst_n(drv_rst_n_b), .led_out(led_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count restart pulses seen on the main instance outside reset.
  always @(negedge clk) begin
    if (rst_n && !drv_rst_n) pulse_cnt = pulse_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  // Clean 6-cycle press; returns on the release cycle.
  task automatic press_short();
    key_n = 1'b0;
    tick(6);
    key_n = 1'b1;
  endtask

  logic [1:0] exp_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] exp_led  [4] = '{8'h22, 8'h44, 8'h88, 8'h11};

  initial begin
    rst_n    = 1'b0;
    key_n    = 1'b1;
    key_b_n  = 1'b1;
    mode_led = 32'h8844_2211;

    // 1: reset and release
    tick(2);
    check_val("t1_rst_drv", {31'd0, drv_rst_n}, 32'd0);
    check_val("t1_rst_mode", {30'd0, mode_sel}, 32'd0);
    check_val("t1_rst_led", {24'd0, led_out}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("t1_drv_after_rel", {31'd0, drv_rst_n}, 32'd0);
    tick(1);
    check_val("t1_drv_high", {31'd0, drv_rst_n}, 32'd1);
    check_val("t1_led_restart", {24'd0, led_out}, 32'd0);
    tick(1);
    check_val("t1_led_mode0", {24'd0, led_out}, 32'h11);
    mode_led[7:0] = 8'h5A;
    tick(1);
    check_val("t1_led_follow", {24'd0, led_out}, 32'h5A);
    mode_led[7:0] = 8'h11;
    tick(1);
    check_val("t1_led_back", {24'd0, led_out}, 32'h11);

    // 2: press held 8 cycles then release
    p0 = pulse_cnt;
    key_n = 1'b0;
    tick(8);
    key_n = 1'b1;
    tick(5);
    check_val("t2_led_before_dark", {24'd0, led_out}, 32'h11);
    bad_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (led_out !== 8'h00 || drv_rst_n !== 1'b1 || mode_sel !== 2'd0) bad_cyc++;
    end
    check_val("t2_dark_cycles", bad_cyc, 32'd0);
    tick(1);
    check_val("t2_restart_drv", {31'd0, drv_rst_n}, 32'd0);
    check_val("t2_restart_mode", {30'd0, mode_sel}, 32'd1);
    tick(1);
    check_val("t2_drv_release", {31'd0, drv_rst_n}, 32'd1);
    tick(1);
    check_val("t2_led_mode1", {24'd0, led_out}, 32'h22);
    check_val("t2_pulses", pulse_cnt - p0, 32'd1);

    // 3: bounce every 2 cycles, then stable high
    p0 = pulse_cnt;
    bad_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      key_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      if (led_out !== 8'h22 || mode_sel !== 2'd1) bad_cyc++;
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (led_out !== 8'h22 || mode_sel !== 2'd1) bad_cyc++;
    end
    check_val("t3_bounce_stable", bad_cyc, 32'd0);
    check_val("t3_bounce_pulses", pulse_cnt - p0, 32'd0);

    // 4: four short presses from mode 0 wrap around
    do_reset();
    check_val("t4_start_mode", {30'd0, mode_sel}, 32'd0);
    p0 = pulse_cnt;
    for (int k = 0; k < 4; k++) begin
      press_short();
      tick(14);
      check_val($sformatf("t4_mode_%0d", k), {30'd0, mode_sel}, {30'd0, exp_mode[k]});
      check_val($sformatf("t4_led_%0d", k), {24'd0, led_out}, {24'd0, exp_led[k]});
      tick(2);
    end
    check_val("t4_pulses", pulse_cnt - p0, 32'd4);

    // 5: long press from mode 2
    for (int k = 0; k < 2; k++) begin
      press_short();
      tick(16);
    end
    check_val("t5_start_mode", {30'd0, mode_sel}, 32'd2);
    p0 = pulse_cnt;
    key_n = 1'b0;
    tick(25);
    check_val("t5_led_pre_long", {24'd0, led_out}, 32'h44);
    tick(1);
    check_val("t5_dark_while_held", {24'd0, led_out}, 32'h00);
    tick(4);
    key_n = 1'b1;
    tick(2);
    check_val("t5_restart_drv", {31'd0, drv_rst_n}, 32'd0);
    check_val("t5_mode0", {30'd0, mode_sel}, 32'd0);
    tick(2);
    check_val("t5_led_mode0", {24'd0, led_out}, 32'h11);
    bad_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (led_out !== 8'h11 || mode_sel !== 2'd0) bad_cyc++;
    end
    check_val("t5_release_quiet", bad_cyc, 32'd0);
    check_val("t5_pulses", pulse_cnt - p0, 32'd1);

    // 6a: second press completes inside the long gap and is dropped
    key_b_n = 1'b0;
    tick(6);
    key_b_n = 1'b1;
    tick(4);
    key_b_n = 1'b0;
    tick(5);
    key_b_n = 1'b1;
    tick(3);
    check_val("t6_b_in_blank", {24'd0, led_out_b}, 32'h00);
    tick(13);
    check_val("t6_b_mode", {30'd0, mode_sel_b}, 32'd1);
    check_val("t6_b_led", {24'd0, led_out_b}, 32'h22);
    tick(20);
    check_val("t6_b_mode_final", {30'd0, mode_sel_b}, 32'd1);

    // 6b: reset in the middle of BLANK
    press_short();
    tick(8);
    check_val("t6_in_blank", {24'd0, led_out}, 32'h00);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_mode", {30'd0, mode_sel}, 32'd0);
    check_val("t6_rst_led", {24'd0, led_out}, 32'd0);
    check_val("t6_rst_drv", {31'd0, drv_rst_n}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    #1;
    check_val("t6_drv_after_rel", {31'd0, drv_rst_n}, 32'd0);
    tick(1);
    check_val("t6_drv_high", {31'd0, drv_rst_n}, 32'd1);
    tick(1);
    check_val("t6_led_mode0", {24'd0, led_out}, 32'h11);
    tick(10);
    check_val("t6_mode_next_lost", {30'd0, mode_sel}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
